// File: rtl/uart_rx_buffer.sv
// Receive FIFO between the UART receiver and the j2 I/O read bus, with a status/control register.
// Define UART_RX_IRQ_EN to add the registered rx_irq output and the stored irq_en control bit.
module uart_rx_buffer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter logic [15:0] DATA_ADDR   = 16'h00F1,
  parameter logic [15:0] STATUS_ADDR = 16'h00F2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_rd,
  input  logic             io_read_enable,
  input  logic             io_write_enable,
  input  logic [15:0]      memory_address,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] io_data_out,
  output logic             overflow
`ifdef UART_RX_IRQ_EN
  ,
  output logic             rx_irq
`endif
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned CountW = DEPTH_LOG2 + 1;
  localparam logic [CountW-1:0] FullCount = CountW'(Depth);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                  state_q;
  logic [7:0]              mem_q [Depth];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]       count_q;
  logic                    irq_en;

  logic capture, push, pop, flush, ovf_set, ovf_clr;
  logic non_empty, full;
  logic [7:0]       head;
  logic [WIDTH-1:0] rd_word;

`ifdef UART_RX_IRQ_EN
  logic irq_en_q;
  assign irq_en = irq_en_q;
  logic unused_data;
  assign unused_data = ^{data[WIDTH-1:5], data[1:0]};
`else
  assign irq_en = 1'b0;
  logic unused_data;
  assign unused_data = ^{data[WIDTH-1:4], data[1:0]};
`endif

  assign non_empty = (count_q != '0);
  assign full      = (count_q == FullCount);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    capture = 1'b0;
    flush   = 1'b0;
    ovf_clr = 1'b0;
    pop     = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    if (!reset) begin
      capture = (state_q == StIdle) && rx_valid;
      if (io_write_enable && (memory_address == STATUS_ADDR)) begin
        flush   = data[3];
        ovf_clr = data[2];
      end
      // Flush discards both a same-cycle pop and a same-cycle captured byte.
      pop     = !flush && io_read_enable && (memory_address == DATA_ADDR) && non_empty;
      push    = !flush && capture && (!full || pop);
      ovf_set = !flush && capture && full && !pop;
    end
  end

  always_comb begin
    rd_word = '0;
    if (memory_address == DATA_ADDR) begin
      rd_word[7:0] = non_empty ? head : 8'h00;
      rd_word[8]   = non_empty;
    end else if (memory_address == STATUS_ADDR) begin
      rd_word[0]             = non_empty;
      rd_word[1]             = full;
      rd_word[2]             = overflow;
      rd_word[4]             = irq_en;
      rd_word[8 +: CountW]   = count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_rd       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow    <= 1'b0;
      io_data_out <= '0;
`ifdef UART_RX_IRQ_EN
      irq_en_q    <= 1'b0;
      rx_irq      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          rx_rd   <= capture;
          state_q <= capture ? StHold : StIdle;
        end
        default: begin
          rx_rd   <= 1'b0;
          state_q <= StIdle;
        end
      endcase

      io_data_out <= rd_word;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
          count_q <= count_q - 1'b1;
        end
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

`ifdef UART_RX_IRQ_EN
      if (io_write_enable && (memory_address == STATUS_ADDR)) begin
        irq_en_q <= data[4];
      end
      rx_irq <= irq_en_q && non_empty;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (default depth 16, 32-bit bus).
module tb_uart_rx_buffer;

  localparam logic [15:0] DataAddr   = 16'h00F1;
  localparam logic [15:0] StatusAddr = 16'h00F2;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        io_read_enable;
  logic        io_write_enable;
  logic [15:0] memory_address;
  logic [31:0] data;
  logic [31:0] io_data_out;
  logic        overflow;
`ifdef UART_RX_IRQ_EN
  logic        rx_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int rd_pulses = 0;

  uart_rx_buffer #(
    .WIDTH      (32),
    .DEPTH_LOG2 (4),
    .DATA_ADDR  (DataAddr),
    .STATUS_ADDR(StatusAddr)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_rd          (rx_rd),
    .io_read_enable (io_read_enable),
    .io_write_enable(io_write_enable),
    .memory_address (memory_address),
    .data           (data),
    .io_data_out    (io_data_out),
    .overflow       (overflow)
`ifdef UART_RX_IRQ_EN
    ,
    .rx_irq         (rx_irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && rx_rd) rd_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Receiver model: hold valid until rd, drop it, then let the HOLD cycle pass.
  task automatic send_byte(input logic [7:0] b);
    bit seen = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (rx_rd) seen = 1;
    end
    if (!seen) check("rd_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic read_reg(input logic [15:0] addr, input logic strobe, output logic [31:0] word);
    memory_address = addr;
    io_read_enable = strobe;
    tick();
    word = io_data_out;
    io_read_enable = 1'b0;
    memory_address = 16'h0000;
  endtask

  task automatic write_status(input logic [31:0] wdata);
    memory_address  = StatusAddr;
    io_write_enable = 1'b1;
    data            = wdata;
    tick();
    io_write_enable = 1'b0;
    data            = '0;
    memory_address  = 16'h0000;
  endtask

  initial begin
    logic [31:0] w;
    int p0;
    bit seen;

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    io_read_enable = 1'b0;
    io_write_enable = 1'b0;
    memory_address = '0;
    data = '0;
    tick();
    tick();
    check("reset_data_out", io_data_out, 32'h0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_rx_rd", {31'd0, rx_rd}, 32'd0);
    reset = 1'b0;
    read_reg(StatusAddr, 1'b0, w);
    check("reset_status", w, 32'h0);

    // Single byte
    p0 = rd_pulses;
    send_byte(8'h41);
    check("single_pulses", rd_pulses - p0, 32'd1);
    read_reg(StatusAddr, 1'b1, w);
    check("single_status", w, 32'h101);
    read_reg(DataAddr, 1'b1, w);
    check("single_data", w, 32'h141);
    read_reg(StatusAddr, 1'b1, w);
    check("single_status_after", w, 32'h0);
    read_reg(DataAddr, 1'b1, w);
    check("empty_data", w, 32'h0);
    read_reg(16'h0123, 1'b1, w);
    check("other_addr", w, 32'h0);

    // Fill plus one
    p0 = rd_pulses;
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    check("fill_pulses", rd_pulses - p0, 32'd17);
    check("fill_overflow", {31'd0, overflow}, 32'd1);
    read_reg(StatusAddr, 1'b0, w);
    check("fill_status", w, 32'h1007);
    for (int i = 0; i < 16; i++) begin
      read_reg(DataAddr, 1'b1, w);
      check($sformatf("fill_data%0d", i), w, 32'h100 | i);
    end
    read_reg(StatusAddr, 1'b0, w);
    check("drained_status", w, 32'h004);
    write_status(32'h04);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO, capture and pop in the same cycle
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    memory_address = DataAddr;
    io_read_enable = 1'b1;
    tick();
    check("simul_rd", {31'd0, rx_rd}, 32'd1);
    check("simul_old_head", io_data_out, 32'h180);
    rx_valid = 1'b0;
    io_read_enable = 1'b0;
    tick();
    check("simul_overflow", {31'd0, overflow}, 32'd0);
    read_reg(StatusAddr, 1'b0, w);
    check("simul_status", w, 32'h1003);
    for (int i = 1; i < 16; i++) begin
      read_reg(DataAddr, 1'b1, w);
      check($sformatf("simul_data%0d", i), w, 32'h180 + i);
    end
    read_reg(DataAddr, 1'b1, w);
    check("simul_new_byte", w, 32'h1AA);

    // Flush and clear with overflow set and 5 bytes queued
    for (int i = 0; i < 17; i++) send_byte(8'h20 + 8'(i));
    for (int i = 0; i < 11; i++) read_reg(DataAddr, 1'b1, w);
    read_reg(StatusAddr, 1'b0, w);
    check("five_status", w, 32'h505);
    write_status(32'h0C);
    check("ctl_overflow", {31'd0, overflow}, 32'd0);
    read_reg(StatusAddr, 1'b0, w);
    check("ctl_status", w, 32'h0);
    read_reg(DataAddr, 1'b1, w);
    check("ctl_data", w, 32'h0);

    // Flush with a same-cycle capture: byte lost, no overflow
    rx_valid = 1'b1;
    rx_data = 8'h99;
    memory_address = StatusAddr;
    io_write_enable = 1'b1;
    data = 32'h08;
    tick();
    check("flushpush_rd", {31'd0, rx_rd}, 32'd1);
    rx_valid = 1'b0;
    io_write_enable = 1'b0;
    data = '0;
    tick();
    read_reg(StatusAddr, 1'b0, w);
    check("flushpush_status", w, 32'h0);

    // Overflow set and clear in the same cycle keeps it set
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    rx_valid = 1'b1;
    rx_data = 8'hEE;
    memory_address = StatusAddr;
    io_write_enable = 1'b1;
    data = 32'h04;
    tick();
    rx_valid = 1'b0;
    io_write_enable = 1'b0;
    data = '0;
    tick();
    check("setclr_overflow", {31'd0, overflow}, 32'd1);
    write_status(32'h08);
    read_reg(StatusAddr, 1'b0, w);
    check("flush_keeps_ovf", w, 32'h004);

    // Reset mid-stream with a pending byte
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
    memory_address = StatusAddr;
    rx_valid = 1'b1;
    rx_data = 8'h77;
    reset = 1'b1;
    tick();
    check("rst_data_out", io_data_out, 32'h0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
    reset = 1'b0;
    memory_address = 16'h0000;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (rx_rd) seen = 1;
    end
    check("rst_recapture", {31'd0, seen}, 32'd1);
    rx_valid = 1'b0;
    tick();
    read_reg(StatusAddr, 1'b0, w);
    check("rst_status", w, 32'h101);
    read_reg(DataAddr, 1'b1, w);
    check("rst_data", w, 32'h177);

`ifdef UART_RX_IRQ_EN
    write_status(32'h10);
    read_reg(StatusAddr, 1'b0, w);
    check("irq_en_status", w, 32'h010);
    check("irq_idle", {31'd0, rx_irq}, 32'd0);
    send_byte(8'h55);
    check("irq_set", {31'd0, rx_irq}, 32'd1);
    read_reg(DataAddr, 1'b1, w);
    check("irq_data", w, 32'h155);
    check("irq_still_set", {31'd0, rx_irq}, 32'd1);
    tick();
    check("irq_cleared", {31'd0, rx_irq}, 32'd0);
`else
    write_status(32'h10);
    read_reg(StatusAddr, 1'b0, w);
    check("irq_en_absent", w, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
